// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the FPGA configuration loader.
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    CHECK,
    SETTLE,
    ENABLE,
    DONE,
    ERROR
  } cfg_state_t;

  localparam int DEF_FRAME_W       = 224;
  localparam int DEF_NUM_FRAMES    = 245;
  localparam int DEF_WORD_W        = 32;
  localparam int DEF_SETTLE_CYCLES = 10;
  localparam int DEF_RDY_DELAY     = 4;

  // Stream words needed to fill one tile frame (last word may be partial).
  function automatic int words_per_frame(input int frame_w, input int word_w);
    return (frame_w + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/fpga_cfg_frame_packer.sv
// Packs WORD_W stream words into one FRAME_W tile frame. frame_done strobes
// on the cycle the last word of a frame is accepted; frame then carries the
// complete frame including that word. Bits past FRAME_W are dropped.
module fpga_cfg_frame_packer
  import fpga_cfg_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int WORD_W  = DEF_WORD_W
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               clear,
  input  logic               word_en,
  input  logic [WORD_W-1:0]  word,
  output logic               frame_done,
  output logic [FRAME_W-1:0] frame
);

  localparam int WPF   = words_per_frame(FRAME_W, WORD_W);
  localparam int CNT_W = (WPF > 1) ? $clog2(WPF) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WPF - 1);

  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-1:0] asm_q;
  logic [FRAME_W-1:0] asm_next;

  // Merge the incoming word into its slot of the assembly image.
  always_comb begin
    asm_next = asm_q;
    for (int i = 0; i < FRAME_W; i++) begin
      if (i / WORD_W == int'(cnt)) asm_next[i] = word[i % WORD_W];
    end
  end

  assign frame_done = word_en && (cnt == LAST_WORD);
  assign frame      = asm_next;

  // Word counter and assembly register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      asm_q <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (word_en) begin
      asm_q <= asm_next;
      cnt   <= frame_done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fpga_config_loader.sv
// Configuration controller for the fpga fabric: streams the bitstream into
// tile frames, walks a one-hot configs_en across all tiles, then sequences
// ff_en and rdy. Optional trailer checksum: define FPGA_CFG_CHECKSUM_EN.
module fpga_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int FRAME_W       = DEF_FRAME_W,
  parameter int NUM_FRAMES    = DEF_NUM_FRAMES,
  parameter int WORD_W        = DEF_WORD_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int RDY_DELAY     = DEF_RDY_DELAY
) (
  input  logic                                clock,
  input  logic                                rst,
  input  logic                                start,
  input  logic [WORD_W-1:0]                   cfg_data,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  output logic [FRAME_W-1:0]                  configs_in,
  output logic [NUM_FRAMES-1:0]               configs_en,
  output logic                                ff_en,
  output logic                                rdy,
  output logic                                busy,
  output logic [$clog2(NUM_FRAMES+1)-1:0]     frame_idx,
  output logic                                cfg_err
);

  localparam int IDX_W   = $clog2(NUM_FRAMES + 1);
  localparam int DLY_MAX = (SETTLE_CYCLES > RDY_DELAY) ? SETTLE_CYCLES : RDY_DELAY;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRAMES - 1);

  cfg_state_t         state;
  cfg_state_t         state_next;
  logic               word_en;
  logic               frame_done;
  logic [FRAME_W-1:0] frame;
  logic [DLY_W-1:0]   dly_cnt;
  logic               start_ok;
  logic               last_frame;
  logic               settle_done;
  logic               enable_done;

  assign start_ok    = start && (state == IDLE || state == DONE || state == ERROR);
  assign word_en     = cfg_valid && (state == LOAD);
  assign last_frame  = (frame_idx == LAST_IDX);
  assign settle_done = (state == SETTLE) && (dly_cnt == DLY_W'(SETTLE_CYCLES - 1));
  assign enable_done = (state == ENABLE) && (dly_cnt == DLY_W'(RDY_DELAY - 1));

  fpga_cfg_frame_packer #(
    .FRAME_W (FRAME_W),
    .WORD_W  (WORD_W)
  ) u_packer (
    .clock      (clock),
    .rst        (rst),
    .clear      (start_ok),
    .word_en    (word_en),
    .word       (cfg_data),
    .frame_done (frame_done),
    .frame      (frame)
  );

`ifdef FPGA_CFG_CHECKSUM_EN
  logic [WORD_W-1:0] xor_q;
  logic              trailer_bad;

  assign trailer_bad = (state == CHECK) && cfg_valid && (cfg_data != xor_q);

  // Running XOR of accepted data words; latch a trailer mismatch.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      xor_q   <= '0;
      cfg_err <= 1'b0;
    end else if (start_ok) begin
      xor_q   <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (word_en) xor_q <= xor_q ^ cfg_data;
      if (trailer_bad) cfg_err <= 1'b1;
    end
  end
`else
  assign cfg_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_next = LOAD;
      LOAD:              if (frame_done) state_next = HOLD;
`ifdef FPGA_CFG_CHECKSUM_EN
      HOLD:              state_next = last_frame ? CHECK : LOAD;
      CHECK:             if (cfg_valid) state_next = trailer_bad ? ERROR : SETTLE;
`else
      HOLD:              state_next = last_frame ? SETTLE : LOAD;
`endif
      SETTLE:            if (settle_done) state_next = ENABLE;
      ENABLE:            if (enable_done) state_next = DONE;
      default:           state_next = IDLE;
    endcase
  end

  // Combinational outputs decoded from state.
  always_comb begin
    cfg_ready = (state == LOAD);
`ifdef FPGA_CFG_CHECKSUM_EN
    if (state == CHECK) cfg_ready = 1'b1;
`endif
    busy = !(state == IDLE || state == DONE || state == ERROR);
  end

  // Tile enable shifter, frame index and live-design flags.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      configs_en <= '0;
      frame_idx  <= '0;
      ff_en      <= 1'b0;
      rdy        <= 1'b0;
    end else if (start_ok) begin
      configs_en <= NUM_FRAMES'(1);
      frame_idx  <= '0;
      ff_en      <= 1'b0;
      rdy        <= 1'b0;
    end else begin
      if (state == HOLD) begin
        configs_en <= configs_en << 1;
        frame_idx  <= frame_idx + 1'b1;
      end
      if (settle_done) ff_en <= 1'b1;
      if (enable_done) rdy   <= 1'b1;
    end
  end

  // Frame data register: one update per completed frame, held after load.
  always_ff @(posedge clock or posedge rst) begin
    if (rst)             configs_in <= '0;
    else if (frame_done) configs_in <= frame;
  end

  // Shared settle / ready delay counter, restarted at each phase boundary.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      dly_cnt <= '0;
    end else if (start_ok || settle_done || enable_done) begin
      dly_cnt <= '0;
    end else if (state == SETTLE || state == ENABLE) begin
      dly_cnt <= dly_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Scoreboard bench for fpga_config_loader: a small 8-bit/3-tile instance for
// sequencing corner cases and a default-parameter instance for a full load.
module tb_fpga_config_loader;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- small instance ----------------
  logic       s_start = 1'b0;
  logic [3:0] s_data  = '0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_cin;
  logic [2:0] s_cen;
  logic       s_ff, s_rdy, s_busy, s_err;
  logic [1:0] s_idx;

  fpga_config_loader #(
    .FRAME_W(8), .NUM_FRAMES(3), .WORD_W(4), .SETTLE_CYCLES(2), .RDY_DELAY(1)
  ) u_small (
    .clock(clock), .rst(rst), .start(s_start), .cfg_data(s_data),
    .cfg_valid(s_valid), .cfg_ready(s_ready), .configs_in(s_cin),
    .configs_en(s_cen), .ff_en(s_ff), .rdy(s_rdy), .busy(s_busy),
    .frame_idx(s_idx), .cfg_err(s_err)
  );

  typedef struct packed {
    logic [7:0] frame;
    logic [2:0] en;
    logic [1:0] idx;
  } s_exp_t;

  s_exp_t s_q[$];
  int     s_fcount = 0;
`ifdef FPGA_CFG_CHECKSUM_EN
  logic [3:0] s_xor = '0;
`endif

  // HOLD is the only busy cycle with ready low and a tile enabled.
  always @(negedge clock) begin : s_mon
    s_exp_t e;
    if (!rst && s_busy && !s_ready && s_cen != '0) begin
      check("s_onehot", $onehot(s_cen), 1);
      if (s_q.size() == 0) check("s_unexpected_hold", 0, 1);
      else begin
        e = s_q.pop_front();
        check("s_frame", s_cin, e.frame);
        check("s_en", s_cen, e.en);
        check("s_idx", s_idx, e.idx);
      end
    end
  end

  task automatic send_word(input logic [3:0] d, input bit gappy);
    int n;
    if (gappy) begin
      while ($urandom_range(0, 1) == 1) begin
        @(negedge clock);
        s_valid = 1'b0;
      end
    end
    @(negedge clock);
    s_data  = d;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!s_ready) begin
      check("s_word_timeout", 0, 1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clock);
  endtask

  task automatic push_exp(input logic [7:0] f);
    s_q.push_back('{f, 3'(1 << s_fcount), 2'(s_fcount)});
    s_fcount++;
`ifdef FPGA_CFG_CHECKSUM_EN
    s_xor = s_xor ^ f[3:0] ^ f[7:4];
`endif
  endtask

  task automatic send_frame(input logic [7:0] f, input bit gappy);
    send_word(f[3:0], gappy);
    send_word(f[7:4], gappy);
    push_exp(f);
  endtask

  task automatic begin_load();
    @(negedge clock);
    s_valid = 1'b0;
    s_start = 1'b1;
    @(negedge clock);
    s_start  = 1'b0;
    s_fcount = 0;
`ifdef FPGA_CFG_CHECKSUM_EN
    s_xor = '0;
`endif
    check("s_start_en", s_cen, 3'b001);
    check("s_start_idx", s_idx, 0);
    check("s_start_ff", s_ff, 0);
    check("s_start_rdy", s_rdy, 0);
    check("s_start_busy", s_busy, 1);
    check("s_start_err", s_err, 0);
  endtask

  task automatic wait_done();
    int n;
`ifdef FPGA_CFG_CHECKSUM_EN
    send_word(s_xor, 1'b0);
`endif
    n = 0;
    while (!s_rdy && n < 40) begin
      @(negedge clock);
      n++;
    end
    s_valid = 1'b0;
    check("s_rdy", s_rdy, 1);
    check("s_ff_en", s_ff, 1);
    check("s_cfg_err", s_err, 0);
    check("s_en_done", s_cen, 0);
    check("s_q_empty", s_q.size(), 0);
  endtask

  // ---------------- default instance ----------------
  logic          b_start = 1'b0;
  logic [31:0]   b_data  = '0;
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic [223:0]  b_cin;
  logic [244:0]  b_cen;
  logic          b_ff, b_rdy, b_busy, b_err;
  logic [7:0]    b_idx;

  fpga_config_loader u_big (
    .clock(clock), .rst(rst), .start(b_start), .cfg_data(b_data),
    .cfg_valid(b_valid), .cfg_ready(b_ready), .configs_in(b_cin),
    .configs_en(b_cen), .ff_en(b_ff), .rdy(b_rdy), .busy(b_busy),
    .frame_idx(b_idx), .cfg_err(b_err)
  );

  logic [223:0] b_q[$];
  int           b_shifts = 0;

  always @(negedge clock) begin : b_mon
    logic [244:0] een;
    if (!rst && b_busy && !b_ready && b_cen != '0) begin
      een = '0;
      if (b_shifts < 245) een[b_shifts] = 1'b1;
      b_shifts++;
      if (b_q.size() == 0) check("b_unexpected_hold", 0, 1);
      else check("b_frame", b_cin, b_q.pop_front());
      check("b_en", b_cen, een);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f;
    int n;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_cin", s_cin, 0);
    check("rst_en", s_cen, 0);
    check("rst_ff", s_ff, 0);
    check("rst_rdy", s_rdy, 0);
    check("rst_busy", s_busy, 0);
    check("rst_idx", s_idx, 0);
    check("rst_ready", s_ready, 0);
    check("rst_err", s_err, 0);
    check("rst_b_en", b_cen, 0);
    check("rst_b_cin", b_cin, 0);
    rst = 1'b0;

    // Run A: words 1..6 back-to-back, exact settle/ready timing
    begin_load();
    send_frame(8'h21, 1'b0);
    send_frame(8'h43, 1'b0);
    send_frame(8'h65, 1'b0);
`ifdef FPGA_CFG_CHECKSUM_EN
    send_word(s_xor, 1'b0);
`else
    @(negedge clock);
    @(posedge clock);
`endif
    @(negedge clock);
    check("a_en_zero", s_cen, 0);
    check("a_ff_r1", s_ff, 0);
    @(negedge clock);
    check("a_ff_r2", s_ff, 0);
    @(negedge clock);
    check("a_ff_r3", s_ff, 1);
    check("a_rdy_r3", s_rdy, 0);
    @(negedge clock);
    check("a_rdy_r4", s_rdy, 1);
    check("a_busy_done", s_busy, 0);
    check("a_idx_done", s_idx, 3);
    check("a_cin_held", s_cin, 8'h65);
    check("a_q_empty", s_q.size(), 0);
    // DONE keeps backpressure on excess words
    s_data  = 4'hF;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("a_done_ready", s_ready, 0);
    end
    check("a_cin_stable", s_cin, 8'h65);
    s_valid = 1'b0;

    // Run B: start in DONE, then a stalling stream
    begin_load();
    for (int k = 0; k < 3; k++) begin
      f = 8'($urandom);
      send_frame(f, 1'b1);
    end
    wait_done();

    // Run C: asynchronous reset mid-frame 2, then a clean reload
    begin_load();
    send_frame(8'h9A, 1'b1);
    send_frame(8'h3C, 1'b1);
    send_word(4'h7, 1'b0);
    @(negedge clock);
    #2 rst = 1'b1;
    #1;
    check("c_rst_en", s_cen, 0);
    check("c_rst_cin", s_cin, 0);
    check("c_rst_idx", s_idx, 0);
    check("c_rst_busy", s_busy, 0);
    check("c_rst_ready", s_ready, 0);
    check("c_rst_ff", s_ff, 0);
    check("c_rst_q", s_q.size(), 0);
    @(negedge clock);
    rst     = 1'b0;
    s_valid = 1'b0;
    begin_load();
    send_frame(8'hD2, 1'b1);
    send_frame(8'h5E, 1'b1);
    send_frame(8'hB7, 1'b1);
    wait_done();

    // Run D: start pulsed mid-LOAD is ignored
    begin_load();
    send_frame(8'h18, 1'b0);
    send_word(4'hC, 1'b0);
    @(negedge clock);
    s_valid = 1'b0;
    s_start = 1'b1;
    @(negedge clock);
    s_start = 1'b0;
    check("d_idx_kept", s_idx, 1);
    check("d_en_kept", s_cen, 3'b010);
    send_word(4'h4, 1'b0);
    push_exp(8'h4C);
    send_frame(8'hE1, 1'b1);
    wait_done();

`ifdef FPGA_CFG_CHECKSUM_EN
    // Run E: corrupted trailer
    begin_load();
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    send_frame(8'h47, 1'b0);
    send_word(s_xor ^ 4'h1, 1'b0);
    s_valid = 1'b0;
    repeat (6) @(negedge clock);
    check("e_err", s_err, 1);
    check("e_ff", s_ff, 0);
    check("e_rdy", s_rdy, 0);
    check("e_busy", s_busy, 0);
    begin_load();
    send_frame(8'h0F, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h5A, 1'b0);
    wait_done();
`endif

    // Default parameters: 245 frames of 7 random words
    begin : big_run
`ifdef FPGA_CFG_CHECKSUM_EN
      logic [31:0] b_xor;
      b_xor = '0;
`endif
      @(negedge clock);
      b_start = 1'b1;
      @(negedge clock);
      b_start = 1'b0;
      check("b_start_en", b_cen, 245'd1);
      for (int fi = 0; fi < 245; fi++) begin
        logic [223:0] fr;
        fr = '0;
        for (int w = 0; w < 7; w++) begin
          logic [31:0] d;
          d = $urandom;
          @(negedge clock);
          b_data  = d;
          b_valid = 1'b1;
          n = 0;
          while (!b_ready && n < 20) begin
            @(negedge clock);
            n++;
          end
          if (!b_ready) check("b_word_timeout", 0, 1);
          @(posedge clock);
          fr[w*32 +: 32] = d;
`ifdef FPGA_CFG_CHECKSUM_EN
          b_xor = b_xor ^ d;
`endif
        end
        b_q.push_back(fr);
      end
`ifdef FPGA_CFG_CHECKSUM_EN
      @(negedge clock);
      b_data = b_xor;
      n = 0;
      while (!b_ready && n < 20) begin
        @(negedge clock);
        n++;
      end
      @(posedge clock);
`endif
      @(negedge clock);
      b_valid = 1'b0;
      n = 0;
      while (!b_rdy && n < 100) begin
        @(negedge clock);
        n++;
      end
      check("b_rdy", b_rdy, 1);
      check("b_ff", b_ff, 1);
      check("b_err", b_err, 0);
      check("b_shifts", b_shifts, 245);
      check("b_q_empty", b_q.size(), 0);
      check("b_en_done", b_cen, 0);
      check("b_idx_done", b_idx, 245);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpga_config_loader.md
Name: fpga_config_loader

Overview:
- Synthesizable configuration controller that replaces the file-driven bitstream loading in the fabric wrapper.
- Accepts the bitstream as a valid/ready word stream and packs the words into FRAME_W-bit tile frames.
- Drives the fabric's `configs_in` and one-hot `configs_en` buses, then sequences `ff_en` and `rdy` once every tile is written.
- Sits directly upstream of the `fpga` fabric instance.

Parameters:
- FRAME_W, 224: width of one tile configuration frame (`configs_in`).
- NUM_FRAMES, 245: number of tiles, which is also the width of `configs_en`.
- WORD_W, 32: input stream word width. WPF = ceil(FRAME_W/WORD_W) words per frame.
- SETTLE_CYCLES, 10: cycles between the last frame commit and `ff_en` assertion.
- RDY_DELAY, 4: cycles between `ff_en` assertion and `rdy` assertion.

Ports:
- clock, input, 1: sole clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: one-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERROR.
- cfg_data, input, WORD_W: bitstream word.
- cfg_valid, input, 1: `cfg_data` is valid.
- cfg_ready, output, 1: loader accepts a word this cycle.
- configs_in, output, FRAME_W: frame data to the fabric.
- configs_en, output, NUM_FRAMES: one-hot tile write enable.
- ff_en, output, 1: fabric flip-flop enable.
- rdy, output, 1: configuration complete, design live.
- busy, output, 1: high in every state except IDLE, DONE and ERROR.
- frame_idx, output, clog2(NUM_FRAMES+1): index of the frame currently being loaded.
- cfg_err, output, 1: checksum failure. Tied 0 when the optional feature is compiled out.

Behaviour:
- Reset (asynchronous, mid-operation included):
  - state=IDLE.
  - All outputs 0, including `configs_en=0`.
  - Word counter, frame_idx and assembly register cleared.
  - The load aborts with no partial completion.
- State IDLE/DONE/ERROR + start:
  - `configs_en <= 1` (tile 0), `frame_idx <= 0`.
  - `ff_en`, `rdy`, `cfg_err` cleared.
  - Go to LOAD.
- State LOAD:
  - `cfg_ready=1`.
  - Each accepted word k (valid&ready) is written into assembly bits [k*WORD_W +: WORD_W].
  - Bits beyond FRAME_W in the final word are discarded.
  - On the edge accepting word WPF-1: `configs_in` <= full assembled frame (single registered update), word counter cleared, go to HOLD.
  - `cfg_valid` low simply stalls LOAD; there is no timeout.
- State HOLD (exactly 1 cycle):
  - `cfg_ready=0`.
  - `configs_in` is stable while the current `configs_en` bit is high.
  - At the end of the cycle: `configs_en <<= 1` and `frame_idx++`.
  - If the completed frame was NUM_FRAMES-1, `configs_en` becomes all-zero and the state goes to SETTLE (or CHECK when the feature is on). Otherwise back to LOAD.
- Minimum throughput: WPF+1 cycles per frame.
- State SETTLE:
  - Counts SETTLE_CYCLES cycles.
  - Then `ff_en <= 1` and go to ENABLE.
- State ENABLE:
  - Counts RDY_DELAY cycles.
  - Then `rdy <= 1` and go to DONE.
- State DONE:
  - `ff_en=1`, `rdy=1`, `cfg_ready=0`.
  - Excess stream words are not accepted; backpressure is held indefinitely.
- `configs_in` holds its last value after load and is never cleared except by rst.
- `start` while busy is ignored (no restart, no state corruption).
- Only one `configs_en` bit is ever high. It is never high in IDLE or after the final shift.

Optional Feature:
- Macro: FPGA_CFG_CHECKSUM_EN.
- Defined:
  - After the final HOLD, enter CHECK with `cfg_ready=1` and accept one extra word.
  - Compare it against the running XOR of every accepted data word (zero-seeded at start).
  - On match, go to SETTLE.
  - On mismatch, go to ERROR: `cfg_err=1`, `ff_en=0`, `rdy=0`, exit only via start or rst.
- Undefined: no CHECK or ERROR state, no XOR logic, `cfg_err` tied 0.

Decomposition:
- Shared package `fpga_cfg_pkg`:
  - state enum (IDLE, LOAD, HOLD, CHECK, SETTLE, ENABLE, DONE, ERROR);
  - default FRAME_W/NUM_FRAMES/WORD_W constants;
  - WPF computation function.
- One natural sub-module, `fpga_cfg_frame_packer`: word counter plus assembly register, emitting a frame_done strobe and the packed frame.
- FSM, enable shifter and delay counters live in the top module.

Test Plan:
- Small config (FRAME_W=8, WORD_W=4, NUM_FRAMES=3, SETTLE=2, RDY_DELAY=1); start, then words 1,2,3,4,5,6 back-to-back:
  - `configs_in` = 8'h21, 8'h43, 8'h65, each paired with `configs_en` = 3'b001, 3'b010, 3'b100 respectively;
  - `configs_en` = 0 after the last HOLD;
  - `ff_en` rises 2 cycles later; `rdy` rises 1 cycle after `ff_en`.
- `cfg_valid` toggling 50%: identical frames. `cfg_ready` is low in every HOLD cycle; no word is lost or duplicated.
- rst asserted mid-frame 2: all outputs 0 immediately (asynchronous). Then start plus a full stream completes normally from tile 0.
- start pulsed during LOAD: ignored, frame_idx continues. start in DONE: `ff_en`/`rdy` drop, `configs_en`=1, reload succeeds.
- Default parameters, 245×7 random words: exactly 245 `configs_en` shifts, each `configs_in` matches the packed golden model, and `rdy` is set.
- FPGA_CFG_CHECKSUM_EN defined:
  - correct XOR trailer → `rdy=1`, `cfg_err=0`;
  - corrupted trailer → `cfg_err=1`, `ff_en=0`, `rdy=0` held until start.
